// File: rtl/mem_line_arbiter_if.sv
// Cache-side and external-memory-side signals of the two-to-one line-memory arbiter.
// The arbiter takes the slave view; the caches and external memory together drive the master view.
interface mem_line_arbiter_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LINE_W = 128
);
  logic              mem_read_D;
  logic              mem_write_D;
  logic [ADDR_W-1:0] mem_addr_D;
  logic [LINE_W-1:0] mem_wdata_D;
  logic [LINE_W-1:0] mem_rdata_D;
  logic              mem_ready_D;

  logic              mem_read_I;
  logic              mem_write_I;
  logic [ADDR_W-1:0] mem_addr_I;
  logic [LINE_W-1:0] mem_wdata_I;
  logic [LINE_W-1:0] mem_rdata_I;
  logic              mem_ready_I;

  logic              ext_read;
  logic              ext_write;
  logic [ADDR_W-1:0] ext_addr;
  logic [LINE_W-1:0] ext_wdata;
  logic [LINE_W-1:0] ext_rdata;
  logic              ext_ready;

  modport slave (
    input  mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D,
    output mem_rdata_D, mem_ready_D,
    input  mem_read_I, mem_write_I, mem_addr_I, mem_wdata_I,
    output mem_rdata_I, mem_ready_I,
    output ext_read, ext_write, ext_addr, ext_wdata,
    input  ext_rdata, ext_ready
  );

  modport master (
    output mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D,
    input  mem_rdata_D, mem_ready_D,
    output mem_read_I, mem_write_I, mem_addr_I, mem_wdata_I,
    input  mem_rdata_I, mem_ready_I,
    input  ext_read, ext_write, ext_addr, ext_wdata,
    output ext_rdata, ext_ready
  );
endinterface

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter merging the D-cache and I-cache line ports onto one external memory port.
// One line transaction at a time; ready and read data go back only to the issuing port.
module mem_line_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LINE_W = 128
) (
  input logic               clk,
  input logic               rst_n,
  mem_line_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StBusyD,
    StBusyI,
    StRespD,
    StRespI
  } state_e;

  state_e            state_q;
  logic              last_i_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              ext_read_q;
  logic              ext_write_q;
  logic              ready_d_q;
  logic              ready_i_q;
  logic [LINE_W-1:0] rdata_d_q;
  logic [LINE_W-1:0] rdata_i_q;

  logic req_d, req_i, grant_d, grant_i;

  assign req_d = bus.mem_read_D | bus.mem_write_D;
  assign req_i = bus.mem_read_I | bus.mem_write_I;
  // last_i_q set means I was served last, so D wins a tie.
  assign grant_d = req_d & (~req_i | last_i_q);
  assign grant_i = req_i & ~grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_i_q    <= 1'b1;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ext_read_q  <= 1'b0;
      ext_write_q <= 1'b0;
      ready_d_q   <= 1'b0;
      ready_i_q   <= 1'b0;
      rdata_d_q   <= '0;
      rdata_i_q   <= '0;
    end else begin
      ready_d_q <= 1'b0;
      ready_i_q <= 1'b0;
      rdata_d_q <= '0;
      rdata_i_q <= '0;
      case (state_q)
        StIdle: begin
          // A write wins over a simultaneous read on the same port.
          if (grant_d) begin
            addr_q      <= bus.mem_addr_D;
            wdata_q     <= bus.mem_wdata_D;
            write_q     <= bus.mem_write_D;
            ext_write_q <= bus.mem_write_D;
            ext_read_q  <= ~bus.mem_write_D;
            last_i_q    <= 1'b0;
            state_q     <= StBusyD;
          end else if (grant_i) begin
            addr_q      <= bus.mem_addr_I;
            wdata_q     <= bus.mem_wdata_I;
            write_q     <= bus.mem_write_I;
            ext_write_q <= bus.mem_write_I;
            ext_read_q  <= ~bus.mem_write_I;
            last_i_q    <= 1'b1;
            state_q     <= StBusyI;
          end
        end
        StBusyD, StBusyI: begin
          if (bus.ext_ready) begin
            ext_read_q  <= 1'b0;
            ext_write_q <= 1'b0;
            if (state_q == StBusyD) begin
              ready_d_q <= 1'b1;
              rdata_d_q <= write_q ? '0 : bus.ext_rdata;
              state_q   <= StRespD;
            end else begin
              ready_i_q <= 1'b1;
              rdata_i_q <= write_q ? '0 : bus.ext_rdata;
              state_q   <= StRespI;
            end
          end
        end
        StRespD, StRespI: state_q <= StIdle;
        default:          state_q <= StIdle;
      endcase
    end
  end

  assign bus.ext_read    = ext_read_q;
  assign bus.ext_write   = ext_write_q;
  assign bus.ext_addr    = addr_q;
  assign bus.ext_wdata   = wdata_q;
  assign bus.mem_ready_D = ready_d_q;
  assign bus.mem_ready_I = ready_i_q;
  assign bus.mem_rdata_D = rdata_d_q;
  assign bus.mem_rdata_I = rdata_i_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Scoreboard bench for mem_line_arbiter: expected external transactions and per-port
// responses are queued when stimulus is issued and consumed as the DUT produces them.
module tb_mem_line_arbiter;
  localparam int unsigned AW = 28;
  localparam int unsigned LW = 128;

  typedef logic [AW-1:0] addr_t;
  typedef logic [LW-1:0] line_t;
  typedef struct {
    addr_t addr;
    bit    wr;
    line_t wdata;
  } ext_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_line_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  mem_line_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int    n_checks = 0;
  int    n_pass = 0;
  line_t exp_d[$];
  line_t exp_i[$];
  ext_t  exp_ext[$];
  int    mem_lat = 1;
  bit    spur = 1'b0;

  task automatic check(input string tag, input line_t got, input line_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic line_t line_of(input addr_t a);
    return {4'hA, a, 4'h5, ~a, 4'hC, a ^ 28'h5A5A5A5, 4'h3, a + 28'd1};
  endfunction

  task automatic push_ext(input addr_t a, input bit wr, input line_t wd);
    ext_t e;
    e.addr  = a;
    e.wr    = wr;
    e.wdata = wd;
    exp_ext.push_back(e);
  endtask

  // External memory model: checks every strobed cycle against the expected transaction.
  initial begin : mem_model
    int cnt;
    logic [1:0] op_e;
    cnt = 0;
    bus.ext_ready = 1'b0;
    bus.ext_rdata = '0;
    forever begin
      @(negedge clk);
      bus.ext_ready = 1'b0;
      bus.ext_rdata = '0;
      if (!rst_n) begin
        cnt = 0;
      end else if (spur) begin
        bus.ext_ready = 1'b1;
        bus.ext_rdata = line_of(28'h1234567);
        spur = 1'b0;
      end else if (bus.ext_read || bus.ext_write) begin
        if (exp_ext.size() == 0) begin
          check("ext_unexpected", line_t'(1), line_t'(0));
        end else begin
          op_e = exp_ext[0].wr ? 2'b10 : 2'b01;
          check("ext_addr", line_t'(bus.ext_addr), line_t'(exp_ext[0].addr));
          check("ext_op", line_t'({bus.ext_write, bus.ext_read}), line_t'(op_e));
          if (exp_ext[0].wr) check("ext_wdata", bus.ext_wdata, exp_ext[0].wdata);
        end
        cnt++;
        if (cnt >= mem_lat) begin
          cnt = 0;
          bus.ext_ready = 1'b1;
          bus.ext_rdata = bus.ext_read ? line_of(bus.ext_addr) : ~line_of(bus.ext_addr);
          if (exp_ext.size() != 0) void'(exp_ext.pop_front());
        end
      end
    end
  end

  // Response monitor: each ready pulse consumes one expected line; rdata is zero otherwise.
  initial begin : resp_mon
    forever begin
      @(negedge clk);
      if (bus.mem_ready_D) begin
        if (exp_d.size() == 0) check("ready_D_unexpected", line_t'(1), line_t'(0));
        else check("rdata_D", bus.mem_rdata_D, exp_d.pop_front());
      end else begin
        check("rdata_D_idle", bus.mem_rdata_D, '0);
      end
      if (bus.mem_ready_I) begin
        if (exp_i.size() == 0) check("ready_I_unexpected", line_t'(1), line_t'(0));
        else check("rdata_I", bus.mem_rdata_I, exp_i.pop_front());
      end else begin
        check("rdata_I_idle", bus.mem_rdata_I, '0);
      end
    end
  end

  // Issue one line request on a cache port and hold it until its ready pulse.
  task automatic req(input bit is_i, input addr_t a, input bit wr, input line_t wd,
                     output int lat);
    bit done;
    lat  = 0;
    done = 1'b0;
    @(negedge clk);
    if (is_i) begin
      exp_i.push_back(wr ? '0 : line_of(a));
      bus.mem_addr_I  = a;
      bus.mem_wdata_I = wd;
      bus.mem_read_I  = !wr;
      bus.mem_write_I = wr;
    end else begin
      exp_d.push_back(wr ? '0 : line_of(a));
      bus.mem_addr_D  = a;
      bus.mem_wdata_D = wd;
      bus.mem_read_D  = !wr;
      bus.mem_write_D = wr;
    end
    while (!done && lat <= 400) begin
      @(negedge clk);
      lat++;
      done = is_i ? bus.mem_ready_I : bus.mem_ready_D;
    end
    if (!done) check(is_i ? "timeout_I" : "timeout_D", line_t'(0), line_t'(1));
    if (is_i) begin
      bus.mem_read_I  = 1'b0;
      bus.mem_write_I = 1'b0;
      bus.mem_addr_I  = '0;
      bus.mem_wdata_I = '0;
    end else begin
      bus.mem_read_D  = 1'b0;
      bus.mem_write_D = 1'b0;
      bus.mem_addr_D  = '0;
      bus.mem_wdata_D = '0;
    end
  endtask

  task automatic do_reset(input bit check_outputs);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    if (check_outputs) begin
      check("rst_ext_read", line_t'(bus.ext_read), '0);
      check("rst_ext_write", line_t'(bus.ext_write), '0);
      check("rst_ext_addr", line_t'(bus.ext_addr), '0);
      check("rst_ext_wdata", bus.ext_wdata, '0);
      check("rst_ready_D", line_t'(bus.mem_ready_D), '0);
      check("rst_ready_I", line_t'(bus.mem_ready_I), '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int lat_d, lat_i, k;
    bus.mem_read_D  = 1'b0;
    bus.mem_write_D = 1'b0;
    bus.mem_addr_D  = '0;
    bus.mem_wdata_D = '0;
    bus.mem_read_I  = 1'b0;
    bus.mem_write_I = 1'b0;
    bus.mem_addr_I  = '0;
    bus.mem_wdata_I = '0;
    #2 rst_n = 1'b0;
    do_reset(1'b1);

    // Lone D read, 4-cycle memory: strobe one cycle after the request, ready at latency+1.
    mem_lat = 4;
    push_ext(28'h0000010, 1'b0, '0);
    fork
      req(1'b0, 28'h0000010, 1'b0, '0, lat_d);
      begin
        @(negedge clk);
        @(negedge clk);
        check("t1_ext_read", line_t'(bus.ext_read), line_t'(1));
        check("t1_ext_addr", line_t'(bus.ext_addr), line_t'(28'h0000010));
      end
    join
    check("t1_latency", line_t'(lat_d), line_t'(5));

    // Simultaneous requests after reset: D first, then I.
    do_reset(1'b0);
    mem_lat = 3;
    push_ext(28'h0000100, 1'b0, '0);
    push_ext(28'h0000200, 1'b0, '0);
    fork
      req(1'b0, 28'h0000100, 1'b0, '0, lat_d);
      req(1'b1, 28'h0000200, 1'b0, '0, lat_i);
    join
    check("t2_D_before_I", line_t'(lat_d < lat_i), line_t'(1));

    // D write-back then D read against a continuously requesting I port.
    mem_lat = 2;
    push_ext(28'h0000AAA, 1'b1, {4{32'hDEAD_BEEF}});
    push_ext(28'h0000300, 1'b0, '0);
    push_ext(28'h0000BBB, 1'b0, '0);
    push_ext(28'h0000310, 1'b0, '0);
    fork
      begin
        req(1'b0, 28'h0000AAA, 1'b1, {4{32'hDEAD_BEEF}}, lat_d);
        req(1'b0, 28'h0000BBB, 1'b0, '0, lat_d);
      end
      begin
        req(1'b1, 28'h0000300, 1'b0, '0, lat_i);
        req(1'b1, 28'h0000310, 1'b0, '0, lat_i);
      end
    join

    // Address change while BUSY_D must not reach the external port.
    mem_lat = 5;
    push_ext(28'h0000040, 1'b0, '0);
    fork
      req(1'b0, 28'h0000040, 1'b0, '0, lat_d);
      begin
        repeat (3) @(negedge clk);
        bus.mem_addr_D = 28'h0000050;
      end
    join

    // Spurious ext_ready in IDLE is ignored.
    mem_lat = 1;
    @(posedge clk);
    #1 spur = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_ready_D", line_t'(bus.mem_ready_D), '0);
    check("t5_ready_I", line_t'(bus.mem_ready_I), '0);
    check("t5_ext_read", line_t'(bus.ext_read), '0);
    @(negedge clk);
    check("t5_ready_D_2", line_t'(bus.mem_ready_D), '0);
    push_ext(28'h0000060, 1'b0, '0);
    req(1'b0, 28'h0000060, 1'b0, '0, lat_d);
    check("t5_latency", line_t'(lat_d), line_t'(2));

    // Reset during BUSY_I drops the strobe at once; the held request restarts afterwards.
    mem_lat = 10;
    push_ext(28'h0000700, 1'b0, '0);
    fork
      req(1'b1, 28'h0000700, 1'b0, '0, lat_i);
      begin
        repeat (4) @(negedge clk);
        check("t6_busy_ext_read", line_t'(bus.ext_read), line_t'(1));
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ext_read", line_t'(bus.ext_read), '0);
        check("t6_rst_ready_I", line_t'(bus.mem_ready_I), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (!bus.ext_read && k < 10) begin
          @(negedge clk);
          k++;
        end
        check("t6_restart_ext_read", line_t'(bus.ext_read), line_t'(1));
        check("t6_restart_addr", line_t'(bus.ext_addr), line_t'(28'h0000700));
      end
    join

    repeat (3) @(negedge clk);
    check("exp_d_drained", line_t'(exp_d.size()), '0);
    check("exp_i_drained", line_t'(exp_i.size()), '0);
    check("exp_ext_drained", line_t'(exp_ext.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
